// File: rtl/probe_pkg.sv
// probe_pkg: definitions shared by the probe transmit and receive switch blocks.
//   - probe-mode codes carried on PROBE_MODE
//   - two-bit edge codes: {previous, current} sample of a synchronized signal
//   - transmit-switch FSM state encoding
//   - helper that says whether a probe mode fires the pulser
package probe_pkg;

  localparam logic [7:0] MODE_SR    = 8'd1;  // send and receive
  localparam logic [7:0] MODE_TX    = 8'd2;  // send only
  localparam logic [7:0] MODE_RX    = 8'd3;  // receive only
  localparam logic [7:0] MODE_CLOSE = 8'd4;  // close test

  localparam logic [1:0] RAISE = 2'b01;
  localparam logic [1:0] FALL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    FIRE = 2'd2,
    POST = 2'd3
  } tx_state_t;

  // Only the two sending modes ever drive the pulser.
  function automatic logic mode_transmits(input logic [7:0] mode);
    return (mode == MODE_SR) || (mode == MODE_TX);
  endfunction

endpackage

// File: rtl/tx_pulse_gen.sv
// tx_pulse_gen: bipolar excitation burst generator.
// A start pulse launches burst_len periods. Each period is half_period cycles
// of tx_p followed by half_period cycles of tx_n. Outputs come straight from
// flops. done is high during the last cycle of the burst, so the controlling
// FSM can leave FIRE on the same edge that drops the drive.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous abort, returns to idle on the next edge
//   start        : one-cycle launch; sampled on the edge that begins drive
//   half_period  : cycles per half-cycle (>= 1)
//   burst_len    : periods per burst (>= 1), must be stable while start is high
//   tx_p, tx_n   : positive / negative drive
//   done         : last active cycle of the burst
module tx_pulse_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] half_period,
  input  logic [7:0] burst_len,
  output logic       tx_p,
  output logic       tx_n,
  output logic       done
);

  logic       active_q, active_d;
  logic [7:0] hp_cnt_q, hp_cnt_d;     // cycles left in the current half-cycle
  logic [8:0] half_cnt_q, half_cnt_d; // half-cycles left after the current one
  logic       tx_p_q, tx_p_d;
  logic       tx_n_q, tx_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      hp_cnt_q   <= 8'd0;
      half_cnt_q <= 9'd0;
      tx_p_q     <= 1'b0;
      tx_n_q     <= 1'b0;
    end else begin
      active_q   <= active_d;
      hp_cnt_q   <= hp_cnt_d;
      half_cnt_q <= half_cnt_d;
      tx_p_q     <= tx_p_d;
      tx_n_q     <= tx_n_d;
    end
  end

  always_comb begin
    active_d   = active_q;
    hp_cnt_d   = hp_cnt_q;
    half_cnt_d = half_cnt_q;
    tx_p_d     = tx_p_q;
    tx_n_d     = tx_n_q;
    if (clear) begin
      active_d   = 1'b0;
      hp_cnt_d   = 8'd0;
      half_cnt_d = 9'd0;
      tx_p_d     = 1'b0;
      tx_n_d     = 1'b0;
    end else if (start) begin
      active_d   = 1'b1;
      hp_cnt_d   = half_period - 8'd1;
      half_cnt_d = {burst_len, 1'b0} - 9'd1;
      tx_p_d     = 1'b1;
      tx_n_d     = 1'b0;
    end else if (active_q) begin
      if (hp_cnt_q == 8'd0) begin
        if (half_cnt_q == 9'd0) begin
          active_d = 1'b0;
          tx_p_d   = 1'b0;
          tx_n_d   = 1'b0;
        end else begin
          half_cnt_d = half_cnt_q - 9'd1;
          hp_cnt_d   = half_period - 8'd1;
          // Polarity alternates every half-cycle; never both high.
          tx_p_d     = ~tx_p_q;
          tx_n_d     = tx_p_q;
        end
      end else begin
        hp_cnt_d = hp_cnt_q - 8'd1;
      end
    end
  end

  assign tx_p = tx_p_q;
  assign tx_n = tx_n_q;
  assign done = active_q && (hp_cnt_q == 8'd0) && (half_cnt_q == 9'd0);

endmodule

// File: rtl/transmit_switch.sv
// transmit_switch: shot sequencer for the probe T/R switch and pulser.
// A rising edge of TRIG (2-flop synchronized) starts a shot when idle,
// enabled, in a sending mode and with a non-zero burst length:
//   IDLE -> PRE (PRE_GUARD cycles, switch ON) -> FIRE (burst, MA high)
//   -> POST (POST_GUARD cycles) -> IDLE (switch OFF).
// Triggers arriving while a shot is in progress are dropped, not queued.
// SW_EN low aborts everything on the next edge.
//   CLOCK_10M, RST_N : clock, asynchronous active-low reset
//   SW_EN            : global enable
//   PROBE_MODE       : probe mode code (see probe_pkg)
//   TRIG             : asynchronous shot request, rising edge used
//   BURST_LEN        : drive periods per shot, latched at acceptance
//   GEN              : one-cycle shot-start marker
//   MA               : high during the excitation burst
//   TX_P, TX_N       : bipolar drive
//   TRANSMIT_SW      : T/R switch control, ON during a shot
//   BUSY             : shot in progress
//   DBG_STATE        : current FSM state, for observation
// Handshake: there is none; TRIG is a level-edge request with no
// acknowledge other than GEN, and a request that is not accepted is lost.
module transmit_switch
  import probe_pkg::*;
#(
  parameter logic        ON          = 1'b0,
  parameter logic        OFF         = 1'b1,
  parameter logic [15:0] PRE_GUARD   = 16'd20,
  parameter logic [15:0] POST_GUARD  = 16'd20,
  parameter logic [7:0]  HALF_PERIOD = 8'd2
) (
  input  logic       CLOCK_10M,
  input  logic       RST_N,
  input  logic       SW_EN,
  input  logic [7:0] PROBE_MODE,
  input  logic       TRIG,
  input  logic [7:0] BURST_LEN,
  output logic       GEN,
  output logic       MA,
  output logic       TX_P,
  output logic       TX_N,
  output logic       TRANSMIT_SW,
  output logic       BUSY,
  output logic [1:0] DBG_STATE
);

  tx_state_t  state_q, state_d;
  logic [15:0] guard_q, guard_d;
  logic [7:0]  burst_q, burst_d;
  logic        trig_s1_q, trig_s1_d;
  logic        trig_s2_q, trig_s2_d;
  logic        trig_s3_q, trig_s3_d;  // previous synchronized sample
  logic        gen_q, gen_d;
  logic        ma_q, ma_d;
  logic        sw_q, sw_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        fire_start;
  logic        pg_done;

  // State register (and all other flops).
  always_ff @(posedge CLOCK_10M or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      guard_q   <= 16'd0;
      burst_q   <= 8'd0;
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
      gen_q     <= 1'b0;
      ma_q      <= 1'b0;
      sw_q      <= OFF;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      burst_q   <= burst_d;
      trig_s1_q <= trig_s1_d;
      trig_s2_q <= trig_s2_d;
      trig_s3_q <= trig_s3_d;
      gen_q     <= gen_d;
      ma_q      <= ma_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
    end
  end

  // Trigger synchronizer; cleared while disabled.
  always_comb begin
    trig_s1_d = 1'b0;
    trig_s2_d = 1'b0;
    trig_s3_d = 1'b0;
    if (SW_EN) begin
      trig_s1_d = TRIG;
      trig_s2_d = trig_s1_q;
      trig_s3_d = trig_s2_q;
    end
  end

  assign accept = (state_q == IDLE) && SW_EN
               && mode_transmits(PROBE_MODE)
               && (BURST_LEN != 8'd0)
               && ({trig_s3_q, trig_s2_q} == RAISE);

  // Next-state logic, including the guard counter and burst latch.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    burst_d = burst_q;
    if (!SW_EN) begin
      state_d = IDLE;
      guard_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = PRE;
            guard_d = PRE_GUARD - 16'd1;
            burst_d = BURST_LEN;
          end
        end
        PRE: begin
          if (guard_q == 16'd0) state_d = FIRE;
          else                  guard_d = guard_q - 16'd1;
        end
        FIRE: begin
          if (pg_done) begin
            state_d = POST;
            guard_d = POST_GUARD - 16'd1;
          end
        end
        POST: begin
          if (guard_q == 16'd0) state_d = IDLE;
          else                  guard_d = guard_q - 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so they change on the
  // same edge as the state they belong to.
  always_comb begin
    gen_d  = accept;
    ma_d   = (state_d == FIRE);
    sw_d   = (state_d != IDLE) ? ON : OFF;
    busy_d = (state_d != IDLE);
  end

  assign fire_start = (state_q == PRE) && (state_d == FIRE);

  tx_pulse_gen u_pulse (
    .clk         (CLOCK_10M),
    .rst_n       (RST_N),
    .clear       (~SW_EN),
    .start       (fire_start),
    .half_period (HALF_PERIOD),
    .burst_len   (burst_q),
    .tx_p        (TX_P),
    .tx_n        (TX_N),
    .done        (pg_done)
  );

  assign GEN         = gen_q;
  assign MA          = ma_q;
  assign TRANSMIT_SW = sw_q;
  assign BUSY        = busy_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_transmit_switch.sv
// Directed bench for transmit_switch with default parameters.
module tb_transmit_switch;

  logic       clk;
  logic       rst_n;
  logic       sw_en;
  logic [7:0] probe_mode;
  logic       trig;
  logic [7:0] burst_len;
  logic       gen;
  logic       ma;
  logic       tx_p;
  logic       tx_n;
  logic       transmit_sw;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic gen_prev = 1'b0;

  // Clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  transmit_switch dut (
    .CLOCK_10M   (clk),
    .RST_N       (rst_n),
    .SW_EN       (sw_en),
    .PROBE_MODE  (probe_mode),
    .TRIG        (trig),
    .BURST_LEN   (burst_len),
    .GEN         (gen),
    .MA          (ma),
    .TX_P        (tx_p),
    .TX_N        (tx_n),
    .TRANSMIT_SW (transmit_sw),
    .BUSY        (busy),
    .DBG_STATE   (dbg_state)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n active edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gen"}, gen, 1'b0);
    chk({tag, "_ma"}, ma, 1'b0);
    chk({tag, "_txp"}, tx_p, 1'b0);
    chk({tag, "_txn"}, tx_n, 1'b0);
    chk({tag, "_sw"}, transmit_sw, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Full shot from a TRIG raised just before edge k; checks every cycle.
  // retrig: second TRIG during FIRE and a switch to receive-only mid-shot.
  task automatic run_shot(input int len, input bit retrig);
    int fe;
    logic e_ma, e_p, e_n, e_on;
    fe = 22 + 4 * len;
    burst_len = len[7:0];
    trig = 1'b1;
    for (int t = 0; t < fe + 30; t++) begin
      step(1);
      e_ma = (t >= 22) && (t < fe);
      e_p  = e_ma && (((t - 22) % 4) < 2);
      e_n  = e_ma && !e_p;
      e_on = (t >= 2) && (t < fe + 20);
      chk("shot_gen", gen, (t == 2));
      chk("shot_ma", ma, e_ma);
      chk("shot_txp", tx_p, e_p);
      chk("shot_txn", tx_n, e_n);
      chk("shot_sw", transmit_sw, !e_on);
      chk("shot_busy", busy, e_on);
      if (t == 1) trig = 1'b0;
      if (t == 5) burst_len = 8'd7;  // must not alter the latched length
      if (retrig && t == 23) trig = 1'b1;
      if (retrig && t == 25) trig = 1'b0;
      if (retrig && t == 30) probe_mode = 8'd3;
    end
    probe_mode = 8'd1;
    burst_len  = 8'd3;
  endtask

  // Trigger that must be rejected.
  task automatic no_shot(input logic [7:0] mode, input logic [7:0] len);
    probe_mode = mode;
    burst_len  = len;
    trig = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step(1);
      chk_idle("reject");
      if (t == 1) trig = 1'b0;
    end
    probe_mode = 8'd1;
    burst_len  = 8'd3;
  endtask

  // Invariant checker
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_overlap", tx_p & tx_n, 1'b0);
      chk("inv_drive_sw", (tx_p | tx_n) & transmit_sw, 1'b0);
      chk("inv_gen_width", gen & gen_prev, 1'b0);
      chk("inv_ma_sw", ma & transmit_sw, 1'b0);
      gen_prev = gen;
    end else begin
      gen_prev = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0;
    sw_en = 1'b1;
    probe_mode = 8'd1;
    trig = 1'b0;
    burst_len = 8'd3;
    step(2);
    chk_idle("reset");
    chk("reset_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    step(3);
    chk_idle("post_reset");

    // Nominal shot, mode 1, length 3
    run_shot(3, 1'b0);
    chk("after_shot_state", dbg_state, 2'd0);

    // Send-only mode, length 1 (smallest burst)
    probe_mode = 8'd2;
    run_shot(1, 1'b0);

    // Rejected triggers
    no_shot(8'd3, 8'd3);
    no_shot(8'd4, 8'd3);
    no_shot(8'd1, 8'd0);

    // Retrigger and mode change mid-shot; nothing follows the shot
    run_shot(3, 1'b1);
    for (int t = 0; t < 20; t++) begin
      step(1);
      chk_idle("no_second");
    end

    // Enable dropped during FIRE
    trig = 1'b1;
    for (int t = 0; t <= 25; t++) begin
      step(1);
      if (t == 1) trig = 1'b0;
    end
    chk("abort_pre_ma", ma, 1'b1);
    chk("abort_pre_txn", tx_n, 1'b1);
    sw_en = 1'b0;
    step(1);
    chk_idle("abort");
    chk("abort_state", dbg_state, 2'd0);
    step(3);
    sw_en = 1'b1;
    step(3);
    run_shot(2, 1'b0);

    // Asynchronous reset mid-PRE
    trig = 1'b1;
    step(2);
    trig = 1'b0;
    step(8);
    chk("rst_pre_busy", busy, 1'b1);
    chk("rst_pre_sw", transmit_sw, 1'b0);
    #20;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_state", dbg_state, 2'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    run_shot(3, 1'b0);

    // Randomized triggers, checked by the invariant checker
    for (int i = 0; i < 10; i++) begin
      probe_mode = 8'($urandom_range(1, 4));
      burst_len  = 8'($urandom_range(0, 4));
      trig = 1'b1;
      step($urandom_range(2, 6));
      trig = 1'b0;
      step($urandom_range(2, 80));
    end
    probe_mode = 8'd1;
    for (int t = 0; t < 200 && busy; t++) step(1);
    step(1);
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmit_switch.md
# transmit_switch

Transmit-side counterpart of the probe receive switch. On a trigger it sequences the probe T/R switch, drives a bipolar excitation burst, and emits the `GEN` and `MA` markers that the receive-switch logic consumes. GEN marks the start of a shot; MA falling marks the end of excitation and starts receive blanking. The block sits between the shot/PRF scheduler and the pulser front-end.

## Interface
Parameters:
- `ON`, 1'b0: active level of `TRANSMIT_SW`.
- `OFF`, 1'b1: inactive level of `TRANSMIT_SW`.
- `PRE_GUARD`, 16'd20: cycles between switch ON and first drive edge. Must be ≥ 1.
- `POST_GUARD`, 16'd20: cycles between end of drive and switch OFF. Must be ≥ 1.
- `HALF_PERIOD`, 8'd2: cycles per drive half-cycle. Must be ≥ 1. Default gives 2.5 MHz at 10 MHz.

Ports:
- `CLOCK_10M` in 1: the single clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `SW_EN` in 1: global enable. Low aborts the block and forces idle outputs.
- `PROBE_MODE` in 8: 1 send & receive, 2 send-only, 3 receive-only, 4 close test.
- `TRIG` in 1: shot request, asynchronous. Only its rising edge is used.
- `BURST_LEN` in 8: number of drive periods per shot. Latched at trigger.
- `GEN` out 1: one-cycle shot-start pulse.
- `MA` out 1: high while the excitation burst is active.
- `TX_P` out 1: positive drive.
- `TX_N` out 1: negative drive.
- `TRANSMIT_SW` out 1: T/R switch control; `ON` while the shot is in progress.
- `BUSY` out 1: high from shot start until the switch is released.

## Operation
- Reset / `SW_EN` low:
  - state IDLE.
  - `GEN`=`MA`=`TX_P`=`TX_N`=`BUSY`=0, `TRANSMIT_SW`=`OFF`.
  - Counters and sync flops cleared.
  - Deasserting `SW_EN` mid-shot aborts immediately, effective at the next edge.
- `TRIG` path: 2-flop synchronizer, then rising-edge detect on the synchronized signal.
- A trigger is accepted only when all of the following hold; otherwise it is dropped and not queued:
  - state is IDLE,
  - `SW_EN`=1,
  - `PROBE_MODE` is 1 or 2,
  - `BURST_LEN` ≠ 0.
- `PROBE_MODE` and `BURST_LEN` are sampled at acceptance. Later changes do not affect the shot in progress.
- FSM states and transitions:
  - IDLE → PRE on an accepted trigger. `GEN`=1 for that one cycle; `TRANSMIT_SW`=`ON`; `BUSY`=1.
  - PRE: lasts `PRE_GUARD` cycles, then → FIRE.
  - FIRE: lasts `BURST_LEN`·2·`HALF_PERIOD` cycles, then → POST.
    - `MA`=1 throughout.
    - Each period: `TX_P`=1 for `HALF_PERIOD` cycles, then `TX_N`=1 for `HALF_PERIOD` cycles.
  - POST: lasts `POST_GUARD` cycles, then → IDLE. `TRANSMIT_SW`=`OFF` and `BUSY`=0 take effect on the IDLE entry edge.
- Invariants:
  - `TX_P` & `TX_N` is never 1.
  - Drive is never active unless `TRANSMIT_SW`=`ON`.
  - `MA`=0 outside FIRE.
  - All outputs are registered.
- Counters:
  - 16-bit guard counter.
  - 8-bit half-period counter.
  - 9-bit half-cycle counter (2·`BURST_LEN`, max 510). No wrap is possible within the parameter limits.

## Timing
- `TRIG` first sampled high at edge k:
  - `GEN`, `BUSY`, `TRANSMIT_SW`=`ON` at edge k+2.
  - `GEN` low at edge k+3.
- FIRE starts at edge k+2+`PRE_GUARD`, with `MA` and `TX_P` rising on the same edge.
- FIRE ends at edge k+2+`PRE_GUARD`+2·`BURST_LEN`·`HALF_PERIOD`, where `MA` and `TX_N` fall.
- IDLE is entered `POST_GUARD` cycles after FIRE ends. A new trigger can be accepted from the following cycle.
- Minimum `TRIG` high and low pulse width: 2 cycles.

## Structure
- Shared package `probe_pkg`:
  - probe-mode constants `MODE_SR`=1, `MODE_TX`=2, `MODE_RX`=3, `MODE_CLOSE`=4,
  - edge constants `RAISE`=2'b01, `FALL`=2'b10,
  - FSM state enum `tx_state_t` {IDLE, PRE, FIRE, POST}.
- Sub-module `tx_pulse_gen`:
  - inputs: start, `HALF_PERIOD`, burst length.
  - outputs: `TX_P`, `TX_N`, done.
- The top level holds the synchronizer, FSM and guard counter.

## Test plan
All scenarios use default parameters.
- Mode 1, `BURST_LEN`=3, `TRIG` high at edge k:
  - `GEN` 1 cycle at k+2; `MA` high k+22..k+33.
  - `TX_P` at k+22–23, 26–27, 30–31; `TX_N` at k+24–25, 28–29, 32–33.
  - `TRANSMIT_SW`=`ON` k+2..k+53; IDLE and `OFF` at k+54.
- Mode 3, mode 4, and `BURST_LEN`=0 each with a trigger → no `GEN`, `MA` or drive; `TRANSMIT_SW` stays `OFF`.
- Second `TRIG` during FIRE, then a change to `PROBE_MODE`=3 mid-shot → the shot completes unchanged and no second shot follows.
- `SW_EN` dropped at k+25 during FIRE → all outputs reach their idle values at k+26; the next trigger after re-enable produces a normal shot.
- `RST_N` asserted asynchronously mid-PRE → outputs go idle immediately, without waiting for a clock edge.
- Randomized triggers plus an assertion checker:
  - `TX_P` & `TX_N` is never 1,
  - drive is active only while `TRANSMIT_SW`=`ON`,
  - `GEN` is exactly one cycle wide.
